mips_cpu: RTL and testbench
===========================

# mips_cpu

Five-stage pipelined MIPS-subset processor core (IF/ID/EX/MEM/WB) with on-chip instruction and data memories. It is the top of the CPU design. Only a clock and a reset cross its boundary; program load and observation go through fixed hierarchical names. Benches preload instruction memory from a hex file and monitor the fetch PC and the fetched instruction.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-low.
- Required internal names, used by benches:
  - U_IM.imem: instruction memory, reg [31:0] imem[0:1023].
  - U_PC.PC: 32-bit fetch PC.
  - instr: 32-bit wire carrying the IF-stage instruction, imem[PC[11:2]].

## Operation
- Supported instructions; any other encoding executes as a nop:
  - addu (funct 0x21), subu (funct 0x23): R-type, rd written, no overflow trap.
  - ori (op 0x0D): zero-extended immediate, rt written.
  - lui (op 0x0F): imm<<16 written to rt.
  - lw (op 0x23), sw (op 0x2B): sign-extended offset.
  - beq (op 0x04): target = PC+4 + (sext(imm)<<2).
  - j (op 0x02): target = {PC+4[31:28], idx, 2'b00}.
- Register file: 32x32, two read ports, one write port.
  - $0 reads 0 and is never written.
  - Write-before-read bypass: a WB write in the same cycle is visible to an ID read.
- Memories:
  - imem indexed by PC[11:2]; read combinationally.
  - dmem is 1024 words, indexed by addr[11:2], word access only. Read combinationally; written on the clock edge in MEM.
- Control flow:
  - beq and j are resolved in EX; there are no delay slots.
  - On taken beq or j: IF/ID and ID/EX are flushed to nop (2-cycle penalty) and PC is loaded with the target.
  - Not-taken branches have no penalty.
- Hazards:
  - Load-use: an instruction in ID that reads the lw destination held in EX stalls 1 cycle. PC and IF/ID hold; a bubble is inserted into ID/EX.
  - Forwarding: see Configuration.

## Timing
- Reset: on a rising edge with rst=0:
  - PC <= 0x0000_3000.
  - All pipeline registers cleared to nop (all-zero instruction, no writes enabled).
  - All 32 registers cleared to 0.
  - dmem and imem contents are untouched.
- First edge with rst=1: the instruction at 0x3000 enters IF/ID and PC becomes 0x3004.
- Nominal latency: an instruction fetched at edge N writes the register file at edge N+4. Throughput is 1 IPC absent hazards.
- Simultaneous stall and taken branch: the flush wins and PC takes the target.
- Reset asserted mid-program: all in-flight instructions are discarded at that edge and no partial memory write occurs.
- PC wraps modulo 2^32. Out-of-range addresses alias via the [11:2] index.

## Configuration
- MIPS_FORWARD_EN:
  - Defined: EX operands are forwarded from EX/MEM (ALU result) and MEM/WB (ALU or load result), with EX/MEM taking priority. sw store data is forwarded the same way. The only stall is load-use.
  - Undefined: no forwarding paths. ID stalls while any instruction in EX or MEM has a pending write to a register that ID reads (rs/rt, ignoring $0). The register-file bypass covers WB.
  - Architectural results are identical either way; only cycle counts differ.

## Test plan
- Reset: rst=0 for 2 edges, then 1. Required: PC=0x3000, instr=imem[0]. After 1 edge PC=0x3004; registers all 0.
- Back-to-back ALU: program "ori $1,$0,5; ori $2,$0,7; addu $3,$1,$2; subu $4,$3,$1".
  - Required: $3=12, $4=7.
  - 4 instructions complete by edge 8 with forwarding; additional stall cycles without forwarding.
- Load-use: program "lui $1,0x1234; ori $1,$1,0x5678; sw $1,4($0); lw $2,4($0); addu $3,$2,$2".
  - Required: dmem[1]=0x12345678, $3=0x2468ACF0.
  - Exactly one stall cycle when MIPS_FORWARD_EN is defined.
- Taken beq: "beq $0,$0,+2" at 0x3000. Required: the two following instructions never write; the next PC sequence includes 0x300C; 2-cycle penalty.
- j: at 0x3008, target index 0x0C00. Required: PC reaches 0x3000 and the program loops; the instruction at 0x300C never commits.
- Writes to $0 ("ori $0,$0,0xFFFF") leave $0=0. Unknown opcode 0x3F commits nothing.

Source files
------------

// File: rtl/mips_cpu.sv
// mips_cpu: five-stage MIPS-subset core (addu/subu/ori/lui/lw/sw/beq/j) with on-chip imem/dmem.
// Optional feature macro MIPS_FORWARD_EN: EX-stage forwarding; when undefined, ID interlocks instead.

package mips_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_LUI = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       zext;
        logic       is_beq;
        logic       is_j;
        logic       uses_rs;
        logic       uses_rt;
        alu_op_t    aluop;
        logic [4:0] dst;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        case (ins[31:26])
            6'h00: begin
                if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23) begin
                    c.regwrite = 1'b1;
                    c.uses_rs  = 1'b1;
                    c.uses_rt  = 1'b1;
                    c.dst      = ins[15:11];
                    c.aluop    = (ins[5:0] == 6'h23) ? ALU_SUB : ALU_ADD;
                end
            end
            6'h0D: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.zext     = 1'b1;
                c.uses_rs  = 1'b1;
                c.aluop    = ALU_OR;
                c.dst      = ins[20:16];
            end
            6'h0F: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = ALU_LUI;
                c.dst      = ins[20:16];
            end
            6'h23: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.alusrc   = 1'b1;
                c.uses_rs  = 1'b1;
                c.dst      = ins[20:16];
            end
            6'h2B: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.uses_rs  = 1'b1;
                c.uses_rt  = 1'b1;
            end
            6'h04: begin
                c.is_beq  = 1'b1;
                c.uses_rs = 1'b1;
                c.uses_rt = 1'b1;
            end
            6'h02: c.is_j = 1'b1;
            default: c = '0;
        endcase
        // Dropping $0 writes here keeps every hazard compare free of a separate $0 test.
        if (c.dst == 5'd0) c.regwrite = 1'b0;
        return c;
    endfunction
endpackage

// pc: fetch program counter, reset to 0x3000.
// Latency: next value visible one edge after hold/load decision.
// Backpressure: hold freezes the PC; load (taken branch) overrides hold.
module pc (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc_q
);
    logic [31:0] PC;

    always_ff @(posedge clk) begin
        if (!rst)       PC <= 32'h0000_3000;
        else if (load)  PC <= target;
        else if (!hold) PC <= PC + 32'd4;
    end

    assign pc_q = PC;
endmodule

// im: 1024-word instruction memory, preloaded externally.
// Latency: combinational read.
// Backpressure: none.
module im (
    input  logic [9:0]  addr,
    output logic [31:0] dout
);
    logic [31:0] imem [0:1023];

    assign dout = imem[addr];
endmodule

// dm: 1024-word data memory, word access.
// Latency: combinational read, write on the clock edge.
// Backpressure: none; writes suppressed while reset is asserted.
module dm (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdat,
    output logic [31:0] rdat
);
    logic [31:0] dmem [0:1023];

    always_ff @(posedge clk) begin
        if (rst && we) dmem[addr] <= wdat;
    end

    assign rdat = dmem[addr];
endmodule

// rf: 32x32 register file, two read ports, one write port, $0 hardwired to 0.
// Latency: combinational read with same-cycle write-before-read bypass.
// Backpressure: none.
module rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] gpr [0:31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (we && wa != 5'd0) begin
            gpr[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = gpr[ra1];
        rd2 = gpr[ra2];
        if (we && wa == ra1) rd1 = wd;
        if (we && wa == ra2) rd2 = wd;
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end
endmodule

// alu: add/sub/or and lui shift.
// Latency: combinational.
// Backpressure: none.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_OR:  y = a | b;
            ALU_LUI: y = {b[15:0], 16'h0000};
        endcase
    end
endmodule

// mips_cpu: IF/ID/EX/MEM/WB pipeline top.
// Latency: fetch at edge N commits at edge N+4; taken beq/j cost 2 cycles, load-use 1 cycle.
// Backpressure: ID stall holds PC and IF/ID and bubbles ID/EX; a taken branch flush wins over a stall.
module mips_cpu
    import mips_pkg::*;
(
    input logic clk,
    input logic rst
);
    logic [31:0] pc_f, pc4_f, instr;
    logic        stall, taken;
    logic [31:0] br_target;

    logic [31:0] ifid_instr, ifid_pc4;

    ctrl_t       idex_ctrl;
    logic [31:0] idex_pc4, idex_a, idex_b;
    logic [25:0] idex_idx;

    ctrl_t       exmem_ctrl;
    logic [31:0] exmem_alu, exmem_wdat;

    ctrl_t       memwb_ctrl;
    logic [31:0] memwb_alu, memwb_mem;

    ctrl_t       id_ctrl;
    logic [4:0]  id_rs, id_rt;
    logic [31:0] id_a, id_b, wb_dat, mem_rdat;
    logic [31:0] ex_a, ex_b, ex_imm, ex_opb, ex_alu;
    logic        dep_ex;

    pc U_PC (
        .clk    (clk),
        .rst    (rst),
        .hold   (stall),
        .load   (taken),
        .target (br_target),
        .pc_q   (pc_f)
    );

    im U_IM (
        .addr (pc_f[11:2]),
        .dout (instr)
    );

    assign pc4_f = pc_f + 32'd4;

    assign id_ctrl = decode(ifid_instr);
    assign id_rs   = ifid_instr[25:21];
    assign id_rt   = ifid_instr[20:16];
    assign wb_dat  = memwb_ctrl.memtoreg ? memwb_mem : memwb_alu;

    rf U_RF (
        .clk (clk),
        .rst (rst),
        .ra1 (id_rs),
        .ra2 (id_rt),
        .rd1 (id_a),
        .rd2 (id_b),
        .we  (memwb_ctrl.regwrite),
        .wa  (memwb_ctrl.dst),
        .wd  (wb_dat)
    );

    assign dep_ex = idex_ctrl.regwrite &&
                    ((id_ctrl.uses_rs && id_rs == idex_ctrl.dst) ||
                     (id_ctrl.uses_rt && id_rt == idex_ctrl.dst));

`ifdef MIPS_FORWARD_EN
    logic [4:0] idex_rs, idex_rt;

    assign stall = dep_ex && idex_ctrl.memtoreg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_rs <= '0;
            idex_rt <= '0;
        end else begin
            idex_rs <= id_rs;
            idex_rt <= id_rt;
        end
    end

    // EX/MEM beats MEM/WB: it holds the younger value of the same register.
    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        if (exmem_ctrl.regwrite && exmem_ctrl.dst == idex_rs)      ex_a = exmem_alu;
        else if (memwb_ctrl.regwrite && memwb_ctrl.dst == idex_rs) ex_a = wb_dat;
        if (exmem_ctrl.regwrite && exmem_ctrl.dst == idex_rt)      ex_b = exmem_alu;
        else if (memwb_ctrl.regwrite && memwb_ctrl.dst == idex_rt) ex_b = wb_dat;
    end
`else
    logic dep_mem;

    assign dep_mem = exmem_ctrl.regwrite &&
                     ((id_ctrl.uses_rs && id_rs == exmem_ctrl.dst) ||
                      (id_ctrl.uses_rt && id_rt == exmem_ctrl.dst));
    assign stall   = dep_ex || dep_mem;
    assign ex_a    = idex_a;
    assign ex_b    = idex_b;
`endif

    assign ex_imm = idex_ctrl.zext ? {16'h0000, idex_idx[15:0]}
                                   : {{16{idex_idx[15]}}, idex_idx[15:0]};
    assign ex_opb = idex_ctrl.alusrc ? ex_imm : ex_b;

    alu U_ALU (
        .a  (ex_a),
        .b  (ex_opb),
        .op (idex_ctrl.aluop),
        .y  (ex_alu)
    );

    assign taken     = idex_ctrl.is_j || (idex_ctrl.is_beq && ex_a == ex_b);
    assign br_target = idex_ctrl.is_j
                     ? {idex_pc4[31:28], idex_idx, 2'b00}
                     : idex_pc4 + {{14{idex_idx[15]}}, idex_idx[15:0], 2'b00};

    dm U_DM (
        .clk  (clk),
        .rst  (rst),
        .we   (exmem_ctrl.memwrite),
        .addr (exmem_alu[11:2]),
        .wdat (exmem_wdat),
        .rdat (mem_rdat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            idex_ctrl  <= '0;
            idex_pc4   <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_idx   <= '0;
            exmem_ctrl <= '0;
            exmem_alu  <= '0;
            exmem_wdat <= '0;
            memwb_ctrl <= '0;
            memwb_alu  <= '0;
            memwb_mem  <= '0;
        end else begin
            if (taken) begin
                ifid_instr <= '0;
                ifid_pc4   <= '0;
            end else if (!stall) begin
                ifid_instr <= instr;
                ifid_pc4   <= pc4_f;
            end
            // A bubble only needs its control word zeroed; data fields are don't-care.
            idex_ctrl  <= (taken || stall) ? '0 : id_ctrl;
            idex_pc4   <= ifid_pc4;
            idex_a     <= id_a;
            idex_b     <= id_b;
            idex_idx   <= ifid_instr[25:0];
            exmem_ctrl <= idex_ctrl;
            exmem_alu  <= ex_alu;
            exmem_wdat <= ex_b;
            memwb_ctrl <= exmem_ctrl;
            memwb_alu  <= exmem_alu;
            memwb_mem  <= mem_rdat;
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed program bench for mips_cpu: commit stream scoreboard plus PC/register/memory spot checks.
module tb_mips_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    int   last_edge = 0;
    logic [36:0] exp_q [$];

`ifdef MIPS_FORWARD_EN
    localparam int ALU_LAST = 8;
    localparam int LU_LAST  = 10;
`else
    localparam int ALU_LAST = 12;
    localparam int LU_LAST  = 15;
`endif

    mips_cpu dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ecnt = ecnt + 1;
        else     ecnt = 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Register writes happen on the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (rst && dut.memwb_ctrl.regwrite) begin
            last_edge = ecnt + 1;
            chk("commit_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                chk("commit", {27'd0, dut.memwb_ctrl.dst, dut.wb_dat}, {27'd0, exp_q.pop_front()});
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic begin_test();
        rst = 1'b0;
        exp_q.delete();
        last_edge = 0;
        for (int i = 0; i < 1024; i++) dut.U_IM.imem[i] = 32'h0;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] v);
        exp_q.push_back({r, v});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic finish_reset(input logic [31:0] w0);
        logic [31:0] any;
        step(2);
        any = '0;
        for (int i = 0; i < 32; i++) any |= dut.U_RF.gpr[i];
        chk("reset_pc", dut.U_PC.PC, 32'h0000_3000);
        chk("reset_instr", dut.instr, w0);
        chk("reset_regs", any, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] any;

        // Back-to-back ALU with dependencies
        begin_test();
        w = itype(6'h0D, 5'd0, 5'd1, 16'd5);
        dut.U_IM.imem[0] = w;
        dut.U_IM.imem[1] = itype(6'h0D, 5'd0, 5'd2, 16'd7);
        dut.U_IM.imem[2] = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        dut.U_IM.imem[3] = rtype(5'd3, 5'd1, 5'd4, 6'h23);
        expect_wr(5'd1, 32'd5);
        expect_wr(5'd2, 32'd7);
        expect_wr(5'd3, 32'd12);
        expect_wr(5'd4, 32'd7);
        finish_reset(w);
        step(1);
        chk("pc_after_edge1", dut.U_PC.PC, 32'h0000_3004);
        any = '0;
        for (int i = 0; i < 32; i++) any |= dut.U_RF.gpr[i];
        chk("regs_after_edge1", any, 32'h0);
        step(19);
        chk("alu_r3", dut.U_RF.gpr[3], 32'd12);
        chk("alu_r4", dut.U_RF.gpr[4], 32'd7);
        chk("alu_last_edge", last_edge, ALU_LAST);
        chk("alu_drained", exp_q.size(), 0);

        // Load-use through memory
        begin_test();
        w = itype(6'h0F, 5'd0, 5'd1, 16'h1234);
        dut.U_IM.imem[0] = w;
        dut.U_IM.imem[1] = itype(6'h0D, 5'd1, 5'd1, 16'h5678);
        dut.U_IM.imem[2] = itype(6'h2B, 5'd0, 5'd1, 16'd4);
        dut.U_IM.imem[3] = itype(6'h23, 5'd0, 5'd2, 16'd4);
        dut.U_IM.imem[4] = rtype(5'd2, 5'd2, 5'd3, 6'h21);
        expect_wr(5'd1, 32'h1234_0000);
        expect_wr(5'd1, 32'h1234_5678);
        expect_wr(5'd2, 32'h1234_5678);
        expect_wr(5'd3, 32'h2468_ACF0);
        finish_reset(w);
        step(20);
        chk("lu_dmem1", dut.U_DM.dmem[1], 32'h1234_5678);
        chk("lu_r3", dut.U_RF.gpr[3], 32'h2468_ACF0);
        chk("lu_last_edge", last_edge, LU_LAST);
        chk("lu_drained", exp_q.size(), 0);

        // Taken beq skips two instructions
        begin_test();
        w = itype(6'h04, 5'd0, 5'd0, 16'd2);
        dut.U_IM.imem[0] = w;
        dut.U_IM.imem[1] = itype(6'h0D, 5'd0, 5'd5, 16'd1);
        dut.U_IM.imem[2] = itype(6'h0D, 5'd0, 5'd6, 16'd2);
        dut.U_IM.imem[3] = itype(6'h0D, 5'd0, 5'd7, 16'd3);
        dut.U_IM.imem[4] = itype(6'h0D, 5'd0, 5'd8, 16'd4);
        expect_wr(5'd7, 32'd3);
        expect_wr(5'd8, 32'd4);
        finish_reset(w);
        step(3);
        chk("beq_pc_target", dut.U_PC.PC, 32'h0000_300C);
        step(9);
        chk("beq_skipped", dut.U_RF.gpr[5] | dut.U_RF.gpr[6], 32'h0);
        chk("beq_last_edge", last_edge, 9);
        chk("beq_drained", exp_q.size(), 0);

        // j back to 0x3000 loops forever; reset arrives mid-loop
        begin_test();
        w = itype(6'h0D, 5'd0, 5'd9, 16'h0011);
        dut.U_IM.imem[0] = w;
        dut.U_IM.imem[1] = itype(6'h0D, 5'd0, 5'd10, 16'h0022);
        dut.U_IM.imem[2] = {6'h02, 26'h000_0C00};
        dut.U_IM.imem[3] = itype(6'h0D, 5'd0, 5'd11, 16'h0033);
        for (int k = 0; k < 4; k++) begin
            expect_wr(5'd9, 32'h11);
            expect_wr(5'd10, 32'h22);
        end
        finish_reset(w);
        step(4);
        chk("j_pc_fallthru", dut.U_PC.PC, 32'h0000_3010);
        step(1);
        chk("j_pc_target", dut.U_PC.PC, 32'h0000_3000);
        step(17);
        chk("j_r11_never", dut.U_RF.gpr[11], 32'h0);
        chk("j_r9", dut.U_RF.gpr[9], 32'h11);
        chk("j_drained", exp_q.size(), 0);

        // $0 write and unknown opcode commit nothing
        begin_test();
        w = itype(6'h0D, 5'd0, 5'd0, 16'hFFFF);
        dut.U_IM.imem[0] = w;
        dut.U_IM.imem[1] = 32'hFC0A_BEEF;
        dut.U_IM.imem[2] = itype(6'h0D, 5'd0, 5'd12, 16'h005A);
        expect_wr(5'd12, 32'h5A);
        finish_reset(w);
        step(12);
        chk("r0_zero", dut.U_RF.gpr[0], 32'h0);
        chk("r12", dut.U_RF.gpr[12], 32'h5A);
        chk("nop_last_edge", last_edge, 7);
        chk("nop_drained", exp_q.size(), 0);

        rst = 1'b0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
